dds_sweep_controller: RTL and testbench

Upstream control stage for the parameterized DDS. It generates a stepped frequency sweep (linear chirp) by driving the DDS frequency control word, phase offset and enable. Configuration is latched on a start handshake. Up-ramp and triangle (up/down) profiles are supported, each in single-shot or continuous form.

---
 rtl/dds_pkg.sv | 28 ++
 rtl/dds_dwell_timer.sv | 40 ++++
 rtl/dds_sweep_controller.sv | 218 +++++++++++++++++++++
 tb/tb_dds_sweep_controller.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep controller slice: default widths,
// the sweep state encoding and the meaning of the two mode bits.
package dds_pkg;

    localparam int PHASE_WIDTH_DEFAULT = 24;
    localparam int STEP_WIDTH_DEFAULT  = 16;
    localparam int DWELL_WIDTH_DEFAULT = 16;

    // Bit positions inside the 2-bit mode word.
    localparam int MODE_TRI  = 0;  // 1 = triangle (up then down), 0 = up-ramp only
    localparam int MODE_CONT = 1;  // 1 = repeat forever, 0 = single-shot

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } state_t;

    // Mode helpers so the controller reads in terms of intent, not bit numbers.
    function automatic logic is_triangle(input logic [1:0] mode_word);
        return mode_word[MODE_TRI];
    endfunction

    function automatic logic is_continuous(input logic [1:0] mode_word);
        return mode_word[MODE_CONT];
    endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// Per-step dwell timer. The dwell limit is captured on load; while run is
// high the counter walks 0..dwell_l and step_end marks the last cycle of a
// step, so every step lasts dwell_l+1 cycles. With dwell_l=0 step_end stays
// high on every running cycle.
module dds_dwell_timer
    import dds_pkg::*;
#(
    parameter int DWELL_WIDTH = DWELL_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [DWELL_WIDTH-1:0] dwell_in,
    input  logic                   run,
    output logic                   step_end
);

    logic [DWELL_WIDTH-1:0] dwell_l;
    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic                   at_limit;

    assign at_limit = (dwell_cnt == dwell_l);
    assign step_end = run && at_limit;

    // Capture the limit on load; otherwise count while running and wrap at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_l   <= '0;
            dwell_cnt <= '0;
        end else if (load) begin
            dwell_l   <= dwell_in;
            dwell_cnt <= '0;
        end else if (run && !at_limit) begin
            dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
        end else begin
            dwell_cnt <= '0;
        end
    end

endmodule

// File: rtl/dds_sweep_controller.sv
// Stepped-frequency (linear chirp) sweep controller in front of the DDS.
// Configuration is captured on an accepted start; the sweep then walks fcw
// up (and optionally back down) one f_step per dwell period. All outputs
// come straight from registers.
//
// Control handshake: start is a level request sampled on the rising edge and
// accepted only in IDLE with abort low; there is no ready/ack beyond busy,
// which rises the cycle after acceptance and stays high until the sweep ends.
// abort is sampled on every rising edge and, outside IDLE, always wins.
module dds_sweep_controller
    import dds_pkg::*;
#(
    parameter int PHASE_WIDTH = PHASE_WIDTH_DEFAULT,
    parameter int STEP_WIDTH  = STEP_WIDTH_DEFAULT,
    parameter int DWELL_WIDTH = DWELL_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [1:0]             mode,
    input  logic [PHASE_WIDTH-1:0] f_start,
    input  logic [PHASE_WIDTH-1:0] f_step,
    input  logic [STEP_WIDTH-1:0]  num_steps,
    input  logic [DWELL_WIDTH-1:0] dwell,
    input  logic [PHASE_WIDTH-1:0] phase_init,
    output logic [PHASE_WIDTH-1:0] fcw,
    output logic [PHASE_WIDTH-1:0] phase_offset,
    output logic                   dds_enable,
    output logic                   busy,
    output logic                   step_strobe,
    output logic                   sweep_dir,
    output logic                   done,
    output state_t                 state_dbg
);

    // Registered state and latched configuration.
    state_t                 state,       state_n;
    logic [1:0]             mode_l,      mode_n;
    logic [PHASE_WIDTH-1:0] f_start_l,   f_start_n;
    logic [PHASE_WIDTH-1:0] f_step_l,    f_step_n;
    logic [STEP_WIDTH-1:0]  num_steps_l, num_steps_n;
    logic [STEP_WIDTH-1:0]  step_idx,    step_idx_n;

    // Output registers.
    logic [PHASE_WIDTH-1:0] fcw_r,       fcw_n;
    logic [PHASE_WIDTH-1:0] phase_r,     phase_n;
    logic                   enable_r,    enable_n;
    logic                   busy_r,      busy_n;
    logic                   strobe_r,    strobe_n;
    logic                   dir_r,       dir_n;
    logic                   done_r,      done_n;

    // Control between the FSM and the dwell timer.
    logic timer_load;
    logic timer_run;
    logic step_end;
    logic sweep_end;
    logic stop_sweep;

    assign timer_run = (state != IDLE);

    dds_dwell_timer #(
        .DWELL_WIDTH (DWELL_WIDTH)
    ) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .dwell_in (dwell),
        .run      (timer_run),
        .step_end (step_end)
    );

    // Next-state, step-index and fcw update; defaults hold everything and clear pulses.
    always_comb begin
        state_n     = state;
        mode_n      = mode_l;
        f_start_n   = f_start_l;
        f_step_n    = f_step_l;
        num_steps_n = num_steps_l;
        step_idx_n  = step_idx;
        fcw_n       = fcw_r;
        phase_n     = phase_r;
        enable_n    = enable_r;
        busy_n      = busy_r;
        strobe_n    = 1'b0;
        dir_n       = dir_r;
        done_n      = 1'b0;
        timer_load  = 1'b0;
        sweep_end   = 1'b0;
        stop_sweep  = 1'b0;

        case (state)
            IDLE: begin
                // fcw and phase_offset keep their last values while idle.
                if (start && !abort) begin
                    mode_n      = mode;
                    f_start_n   = f_start;
                    f_step_n    = f_step;
                    num_steps_n = num_steps;
                    timer_load  = 1'b1;
                    state_n     = RAMP_UP;
                    fcw_n       = f_start;
                    phase_n     = phase_init;
                    enable_n    = 1'b1;
                    busy_n      = 1'b1;
                    strobe_n    = 1'b1;
                    dir_n       = 1'b0;
                    step_idx_n  = '0;
                end
            end

            RAMP_UP: begin
                if (abort) begin
                    stop_sweep = 1'b1;
                end else if (step_end) begin
                    strobe_n = 1'b1;
                    if (step_idx < num_steps_l) begin
                        fcw_n      = fcw_r + f_step_l;
                        step_idx_n = step_idx + STEP_WIDTH'(1);
                    end else if (is_triangle(mode_l) && (num_steps_l != '0)) begin
                        // Turn around without repeating the top step.
                        state_n    = RAMP_DOWN;
                        dir_n      = 1'b1;
                        fcw_n      = fcw_r - f_step_l;
                        step_idx_n = step_idx - STEP_WIDTH'(1);
                    end else begin
                        sweep_end = 1'b1;
                    end
                end
            end

            RAMP_DOWN: begin
                if (abort) begin
                    stop_sweep = 1'b1;
                end else if (step_end) begin
                    strobe_n = 1'b1;
                    if (step_idx != '0) begin
                        fcw_n      = fcw_r - f_step_l;
                        step_idx_n = step_idx - STEP_WIDTH'(1);
                    end else begin
                        sweep_end = 1'b1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // End of sweep: continuous mode restarts with no gap, single-shot finishes.
        if (sweep_end) begin
            if (is_continuous(mode_l)) begin
                state_n    = RAMP_UP;
                fcw_n      = f_start_l;
                dir_n      = 1'b0;
                step_idx_n = '0;
            end else begin
                stop_sweep = 1'b1;
            end
        end

        // Return to IDLE (completion or abort); fcw is frozen at its last value.
        if (stop_sweep) begin
            state_n    = IDLE;
            enable_n   = 1'b0;
            busy_n     = 1'b0;
            done_n     = 1'b1;
            strobe_n   = 1'b0;
            dir_n      = 1'b0;
            step_idx_n = '0;
        end
    end

    // State, configuration and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mode_l      <= '0;
            f_start_l   <= '0;
            f_step_l    <= '0;
            num_steps_l <= '0;
            step_idx    <= '0;
            fcw_r       <= '0;
            phase_r     <= '0;
            enable_r    <= 1'b0;
            busy_r      <= 1'b0;
            strobe_r    <= 1'b0;
            dir_r       <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state       <= state_n;
            mode_l      <= mode_n;
            f_start_l   <= f_start_n;
            f_step_l    <= f_step_n;
            num_steps_l <= num_steps_n;
            step_idx    <= step_idx_n;
            fcw_r       <= fcw_n;
            phase_r     <= phase_n;
            enable_r    <= enable_n;
            busy_r      <= busy_n;
            strobe_r    <= strobe_n;
            dir_r       <= dir_n;
            done_r      <= done_n;
        end
    end

    assign fcw          = fcw_r;
    assign phase_offset = phase_r;
    assign dds_enable   = enable_r;
    assign busy         = busy_r;
    assign step_strobe  = strobe_r;
    assign sweep_dir    = dir_r;
    assign done         = done_r;
    assign state_dbg    = state;

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Bench for dds_sweep_controller: table of directed sweeps, randomized
// sweeps against a step-list reference model, and hand-written sequences
// for continuous mode, abort, start/abort collisions and mid-sweep reset.
module tb_dds_sweep_controller;
  import dds_pkg::*;

  localparam int PW = 24;
  localparam int SW = 16;
  localparam int DW = 16;
  localparam int CYCLE_BUDGET = 2000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    mode = '0;
  logic [PW-1:0] f_start = '0;
  logic [PW-1:0] f_step = '0;
  logic [SW-1:0] num_steps = '0;
  logic [DW-1:0] dwell = '0;
  logic [PW-1:0] phase_init = '0;
  logic [PW-1:0] fcw;
  logic [PW-1:0] phase_offset;
  logic          dds_enable;
  logic          busy;
  logic          step_strobe;
  logic          sweep_dir;
  logic          done;
  state_t        state_dbg;

  dds_sweep_controller #(
    .PHASE_WIDTH (PW),
    .STEP_WIDTH  (SW),
    .DWELL_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .mode         (mode),
    .f_start      (f_start),
    .f_step       (f_step),
    .num_steps    (num_steps),
    .dwell        (dwell),
    .phase_init   (phase_init),
    .fcw          (fcw),
    .phase_offset (phase_offset),
    .dds_enable   (dds_enable),
    .busy         (busy),
    .step_strobe  (step_strobe),
    .sweep_dir    (sweep_dir),
    .done         (done),
    .state_dbg    (state_dbg)
  );

  // ---------------- types / scoreboard ----------------
  typedef struct {
    logic [1:0]    mode;
    logic [PW-1:0] f_start;
    logic [PW-1:0] f_step;
    logic [SW-1:0] num_steps;
    logic [DW-1:0] dwell;
    logic [PW-1:0] phase_init;
  } cfg_t;

  typedef struct {
    cfg_t          cfg;
    int            exp_cycles;
    int            exp_strobes;
    logic [PW-1:0] exp_last;
  } vec_t;

  // Expected per-cycle output: {sweep_dir, step_strobe, fcw}
  logic [PW+1:0] exp_q[$];

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // A sweep is a list of step numbers k (0..N, then N-1..0 for triangle);
  // step k outputs f_start + k*f_step for dwell+1 cycles, strobe on its first.
  function automatic void add_step(input cfg_t c, input int k, input logic desc);
    logic [PW-1:0] f;
    f = c.f_start + PW'(k) * c.f_step;
    for (int i = 0; i <= int'(c.dwell); i++)
      exp_q.push_back({desc, (i == 0) ? 1'b1 : 1'b0, f});
  endfunction

  function automatic void build_model(input cfg_t c);
    int n;
    n = int'(c.num_steps);
    exp_q.delete();
    for (int k = 0; k <= n; k++) add_step(c, k, 1'b0);
    if (c.mode[MODE_TRI] && n > 0)
      for (int k = n - 1; k >= 0; k--) add_step(c, k, 1'b1);
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.mode       = 2'($urandom_range(0, 1));
    c.f_start    = PW'($urandom);
    c.f_step     = PW'($urandom);
    c.num_steps  = SW'($urandom_range(0, 5));
    c.dwell      = DW'($urandom_range(0, 3));
    c.phase_init = PW'($urandom);
    return c;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_cfg(input cfg_t c);
    mode       = c.mode;
    f_start    = c.f_start;
    f_step     = c.f_step;
    num_steps  = c.num_steps;
    dwell      = c.dwell;
    phase_init = c.phase_init;
  endtask

  // Runs one single-shot sweep from a negedge; start is held one extra cycle
  // with different config to show both are ignored once busy.
  task automatic run_sweep(input cfg_t c, output int cyc, output int strb, output logic [PW-1:0] last);
    cfg_t junk;
    logic [PW+1:0] e;
    int model_len;
    build_model(c);
    model_len = exp_q.size();
    drive_cfg(c);
    start = 1'b1;
    @(negedge clk);
    junk = rand_cfg();
    junk.num_steps = SW'(9);
    drive_cfg(junk);
    cyc = 0;
    strb = 0;
    last = '0;
    while (done !== 1'b1 && cyc < CYCLE_BUDGET) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fcw", fcw, e[PW-1:0]);
        chk("step_strobe", step_strobe, e[PW]);
        chk("sweep_dir", sweep_dir, e[PW+1]);
      end else begin
        chk("sweep_overrun_done", done, 1);
      end
      chk("busy", busy, 1);
      chk("dds_enable", dds_enable, 1);
      chk("phase_offset", phase_offset, c.phase_init);
      strb += int'(step_strobe);
      last = fcw;
      cyc++;
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("sweep_cycles_vs_model", cyc, model_len);
    chk("busy_after", busy, 0);
    chk("enable_after", dds_enable, 0);
    chk("strobe_after", step_strobe, 0);
    chk("fcw_held_at_done", fcw, last);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("fcw_held_idle", fcw, last);
  endtask

  // Continuous sweep checked against the repeating model, aborted after abort_at cycles.
  task automatic run_cont(input cfg_t c, input int abort_at);
    logic [PW+1:0] per[$];
    logic [PW+1:0] e;
    logic [PW-1:0] frozen;
    build_model(c);
    per = exp_q;
    drive_cfg(c);
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < abort_at; i++) begin
      e = per[i % per.size()];
      chk("cont_fcw", fcw, e[PW-1:0]);
      chk("cont_strobe", step_strobe, e[PW]);
      chk("cont_dir", sweep_dir, e[PW+1]);
      chk("cont_no_done", done, 0);
      chk("cont_busy", busy, 1);
      if (i == abort_at - 1) abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    abort = 1'b0;
    frozen = per[(abort_at - 1) % per.size()][PW-1:0];
    chk("abort_done", done, 1);
    chk("abort_busy", busy, 0);
    chk("abort_enable", dds_enable, 0);
    chk("abort_fcw_frozen", fcw, frozen);
    @(negedge clk);
    chk("abort_done_once", done, 0);
    chk("abort_fcw_still", fcw, frozen);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[6];

  initial begin
    int cyc;
    int strb;
    logic [PW-1:0] last;
    logic [PW-1:0] prev;
    cfg_t c;

    vecs[0] = '{cfg: '{2'b00, 24'h001000, 24'h000100, 16'd3, 16'd1, 24'h123456}, exp_cycles: 8,  exp_strobes: 4, exp_last: 24'h001300};
    vecs[1] = '{cfg: '{2'b01, 24'h001000, 24'h000100, 16'd3, 16'd1, 24'h00ABCD}, exp_cycles: 14, exp_strobes: 7, exp_last: 24'h001000};
    vecs[2] = '{cfg: '{2'b00, 24'hFFFF00, 24'h000200, 16'd2, 16'd0, 24'h000001}, exp_cycles: 3,  exp_strobes: 3, exp_last: 24'h000300};
    vecs[3] = '{cfg: '{2'b00, 24'h002000, 24'h000010, 16'd0, 16'd4, 24'h777777}, exp_cycles: 5,  exp_strobes: 1, exp_last: 24'h002000};
    vecs[4] = '{cfg: '{2'b01, 24'h002000, 24'h000010, 16'd0, 16'd4, 24'h000000}, exp_cycles: 5,  exp_strobes: 1, exp_last: 24'h002000};
    vecs[5] = '{cfg: '{2'b01, 24'hFFFF80, 24'h000100, 16'd2, 16'd2, 24'hFEDCBA}, exp_cycles: 15, exp_strobes: 5, exp_last: 24'hFFFF80};

    // Reset
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_fcw", fcw, 0);
    chk("rst_phase", phase_offset, 0);
    chk("rst_enable", dds_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobe", step_strobe, 0);
    chk("rst_dir", sweep_dir, 0);
    chk("rst_done", done, 0);
    chk("rst_state", state_dbg, IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int v = 0; v < 6; v++) begin
      run_sweep(vecs[v].cfg, cyc, strb, last);
      chk("tbl_cycles", cyc, vecs[v].exp_cycles);
      chk("tbl_strobes", strb, vecs[v].exp_strobes);
      chk("tbl_last_fcw", last, vecs[v].exp_last);
    end

    // Randomized single-shot sweeps
    for (int r = 0; r < 20; r++) begin
      c = rand_cfg();
      run_sweep(c, cyc, strb, last);
      chk("rnd_strobes", strb, (c.mode[MODE_TRI] && c.num_steps != 0) ? 2 * int'(c.num_steps) + 1 : int'(c.num_steps) + 1);
    end

    // start and abort together in IDLE, and abort alone in IDLE
    for (int r = 0; r < 3; r++) begin
      prev = fcw;
      c = rand_cfg();
      drive_cfg(c);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("sa_busy", busy, 0);
      chk("sa_enable", dds_enable, 0);
      chk("sa_done", done, 0);
      chk("sa_strobe", step_strobe, 0);
      chk("sa_fcw", fcw, prev);
      @(negedge clk);
      abort = 1'b0;
      chk("idle_abort_no_done", done, 0);
    end

    // Continuous triangle, directed then randomized, each ended by abort
    c = '{2'b11, 24'h001000, 24'h000100, 16'd1, 16'd0, 24'h000042};
    run_cont(c, 10);
    for (int r = 0; r < 4; r++) begin
      c = rand_cfg();
      c.mode[MODE_CONT] = 1'b1;
      run_cont(c, $urandom_range(1, 40));
    end

    // Reset in the middle of RAMP_DOWN, then a clean sweep
    c = vecs[1].cfg;
    drive_cfg(c);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_reset_dir", sweep_dir, 1);
    chk("pre_reset_fcw", fcw, 24'h001200);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_fcw", fcw, 0);
    chk("async_rst_phase", phase_offset, 0);
    chk("async_rst_enable", dds_enable, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_strobe", step_strobe, 0);
    chk("async_rst_dir", sweep_dir, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_state", state_dbg, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_sweep(vecs[0].cfg, cyc, strb, last);
    chk("post_rst_cycles", cyc, vecs[0].exp_cycles);
    chk("post_rst_last", last, vecs[0].exp_last);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
